// File: rtl/matmul_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : matmul_frame_loader
// Brief    : Serial byte-stream loader for the 4x4 signed 8-bit matrix
//            multiplier. Assembles A then B (row-major), holds both stable
//            for the combinational multiply array, checks frame framing and
//            resynchronises on error.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_frame_loader #(
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DW-1:0]    s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [16*DW-1:0] a_flat,
    output logic [16*DW-1:0] b_flat,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             frame_err,
    output logic [7:0]       err_count
);

    localparam logic [3:0] c_LAST_IDX = 4'd15;
    localparam logic [7:0] c_ERR_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_HOLD   = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_idx;
    logic [3:0]      w_idx_nxt;
    logic            w_acc;
    logic            w_wr_a;
    logic            w_wr_b;
    logic            w_err;
    logic [16*DW-1:0] r_a_flat;
    logic [16*DW-1:0] r_b_flat;
    logic            r_frame_err;
    logic [7:0]      r_err_count;

    // Handshake outputs are pure state decodes; rst forces s_ready low.
    assign s_ready   = ~rst & (r_state != ST_HOLD);
    assign m_valid   = (r_state == ST_HOLD);
    assign w_acc     = s_valid & s_ready;
    assign a_flat    = r_a_flat;
    assign b_flat    = r_b_flat;
    assign frame_err = r_frame_err;
    assign err_count = r_err_count;

    // State and element-index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD_A;
            r_idx   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next-state, element write strobes and framing-error detection.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_a      = 1'b0;
        w_wr_b      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_LOAD_A: begin
                if (w_acc) begin
                    if (s_last) begin
                        // Frame ended early: it is already over, so restart directly.
                        w_err       = 1'b1;
                        w_state_nxt = ST_LOAD_A;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_wr_a = 1'b1;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = ST_LOAD_B;
                            w_idx_nxt   = 4'd0;
                        end else begin
                            w_idx_nxt = r_idx + 4'd1;
                        end
                    end
                end
            end
            ST_LOAD_B: begin
                if (w_acc) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_idx_nxt = 4'd0;
                        if (s_last) begin
                            w_wr_b      = 1'b1;
                            w_state_nxt = ST_HOLD;
                        end else begin
                            // 32nd beat lacks s_last: skip the rest of this frame.
                            w_err       = 1'b1;
                            w_state_nxt = ST_DRAIN;
                        end
                    end else if (s_last) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_LOAD_A;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_wr_b    = 1'b1;
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    w_state_nxt = ST_LOAD_A;
                    w_idx_nxt   = 4'd0;
                end
            end
            ST_DRAIN: begin
                if (w_acc && s_last) begin
                    w_state_nxt = ST_LOAD_A;
                    w_idx_nxt   = 4'd0;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD_A;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // Matrix storage: bit-exact element writes on accepted load beats only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_flat <= '0;
            r_b_flat <= '0;
        end else begin
            if (w_wr_a) begin
                r_a_flat[r_idx*DW +: DW] <= s_data;
            end
            if (w_wr_b) begin
                r_b_flat[r_idx*DW +: DW] <= s_data;
            end
        end
    end

    // Framing-error pulse and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_err <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_frame_err <= w_err;
            if (w_err && (r_err_count != c_ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matmul_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_frame_loader
// Brief    : Directed self-checking bench for matmul_frame_loader. Inputs
//            change on the falling edge; outputs are sampled on the falling
//            edge, away from the active rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_frame_loader;

    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [DW-1:0]    s_data;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [16*DW-1:0] a_flat;
    logic [16*DW-1:0] b_flat;
    logic             m_valid;
    logic             m_ready;
    logic             frame_err;
    logic [7:0]       err_count;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ea [16];
    logic [7:0] eb [16];
    logic [127:0] r_exp_a;
    logic [127:0] r_exp_b;

    matmul_frame_loader #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .frame_err (frame_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always terminates.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] m [16]);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = m[i];
        return v;
    endfunction

    // Present one beat and return on the falling edge after it is accepted.
    // s_valid is left high so consecutive calls form a continuous stream.
    task automatic beat(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $error("FAIL beat_timeout: observed s_ready=0 for %0d cycles, required acceptance", n);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input bit gaps);
        for (int i = 0; i < 32; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            beat(i < 16 ? ea[i] : eb[i-16], i == 31);
        end
    endtask

    task automatic fill(input logic [7:0] a0, input logic [7:0] b0);
        for (int i = 0; i < 16; i++) begin
            ea[i] = a0 + 8'(i);
            eb[i] = b0 + 8'(i);
        end
        r_exp_a = pack(ea);
        r_exp_b = pack(eb);
    endtask

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_sready_low", 128'(s_ready), 128'd0);
        chk("rst_a_flat", a_flat, 128'd0);
        chk("rst_b_flat", b_flat, 128'd0);
        chk("rst_m_valid", 128'(m_valid), 128'd0);
        chk("rst_err_count", 128'(err_count), 128'd0);
        chk("rst_frame_err", 128'(frame_err), 128'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_sready", 128'(s_ready), 128'd1);
        @(negedge clk);
        chk("idle_m_valid", 128'(m_valid), 128'd0);

        // Nominal frame: A = 1..16, B = -1..-16, continuous, m_ready high
        for (int i = 0; i < 16; i++) begin
            ea[i] = 8'(i + 1);
            eb[i] = 8'(-(i + 1));
        end
        r_exp_a = pack(ea);
        r_exp_b = pack(eb);
        send_frame(1'b0);
        chk("nom_m_valid_hi", 128'(m_valid), 128'd1);
        chk("nom_s_ready_lo", 128'(s_ready), 128'd0);
        chk("nom_a00", 128'(a_flat[7:0]), 128'h01);
        chk("nom_b33", 128'(b_flat[127:120]), 128'hF0);
        chk("nom_a_flat", a_flat, 128'h100F0E0D0C0B0A090807060504030201);
        chk("nom_b_flat", b_flat, r_exp_b);
        idle(1);
        chk("nom_m_valid_1cyc", 128'(m_valid), 128'd0);
        chk("nom_s_ready_back", 128'(s_ready), 128'd1);
        chk("nom_retain_a", a_flat, r_exp_a);

        // Backpressure: m_ready low for 10 HOLD cycles, random s_valid gaps
        fill(8'h20, 8'hA0);
        m_ready = 1'b0;
        send_frame(1'b1);
        s_valid = 1'b1; s_data = 8'h55; s_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp_m_valid_held", 128'(m_valid), 128'd1);
            chk("bp_s_ready_lo", 128'(s_ready), 128'd0);
            chk("bp_a_stable", a_flat, r_exp_a);
            chk("bp_b_stable", b_flat, r_exp_b);
            @(negedge clk);
        end
        chk("bp_m_valid_11th", 128'(m_valid), 128'd1);
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_m_valid_drop", 128'(m_valid), 128'd0);
        chk("bp_s_ready_rise", 128'(s_ready), 128'd1);
        chk("bp_a_no_accept", a_flat, r_exp_a);
        chk("bp_b_no_accept", b_flat, r_exp_b);
        idle(1);

        // Early s_last on beat 20, then a good frame
        fill(8'h30, 8'hC0);
        for (int i = 0; i < 20; i++) beat(i < 16 ? ea[i] : eb[i-16], i == 19);
        chk("early_frame_err", 128'(frame_err), 128'd1);
        chk("early_err_count", 128'(err_count), 128'd1);
        chk("early_m_valid", 128'(m_valid), 128'd0);
        chk("early_s_ready", 128'(s_ready), 128'd1);
        idle(1);
        chk("early_err_pulse", 128'(frame_err), 128'd0);
        fill(8'h80, 8'h70);
        send_frame(1'b0);
        chk("early_good_m_valid", 128'(m_valid), 128'd1);
        chk("early_good_a00", 128'(a_flat[7:0]), 128'h80);
        chk("early_good_a", a_flat, r_exp_a);
        chk("early_good_b", b_flat, r_exp_b);
        chk("early_cnt_kept", 128'(err_count), 128'd1);
        idle(1);

        // Missing s_last: 32 beats, then 5 drain beats, then a good frame
        fill(8'h40, 8'h50);
        for (int i = 0; i < 32; i++) beat(i < 16 ? ea[i] : eb[i-16], 1'b0);
        chk("miss_frame_err", 128'(frame_err), 128'd1);
        chk("miss_m_valid", 128'(m_valid), 128'd0);
        chk("miss_err_count", 128'(err_count), 128'd2);
        for (int i = 0; i < 5; i++) begin
            beat(8'hE0 + 8'(i), i == 4);
            chk("miss_drain_m_valid", 128'(m_valid), 128'd0);
            chk("miss_drain_no_err", 128'(frame_err), 128'd0);
        end
        idle(1);
        fill(8'h11, 8'h91);
        send_frame(1'b0);
        chk("miss_good_m_valid", 128'(m_valid), 128'd1);
        chk("miss_good_a", a_flat, r_exp_a);
        chk("miss_good_b", b_flat, r_exp_b);
        chk("miss_good_cnt", 128'(err_count), 128'd2);
        idle(1);

        // Reset during LOAD_B beat 8
        fill(8'h60, 8'hD0);
        for (int i = 0; i < 23; i++) beat(i < 16 ? ea[i] : eb[i-16], 1'b0);
        s_data = eb[7];
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_a", a_flat, 128'd0);
        chk("mid_rst_b", b_flat, 128'd0);
        chk("mid_rst_m_valid", 128'(m_valid), 128'd0);
        chk("mid_rst_err_count", 128'(err_count), 128'd0);
        chk("mid_rst_s_ready", 128'(s_ready), 128'd0);
        idle(0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_still_idle", 128'(m_valid), 128'd0);
        fill(8'h05, 8'hF5);
        send_frame(1'b0);
        chk("post_rst_m_valid", 128'(m_valid), 128'd1);
        chk("post_rst_a", a_flat, r_exp_a);
        chk("post_rst_b", b_flat, r_exp_b);
        idle(1);

        // Saturation: 260 consecutive early-s_last errors
        for (int i = 0; i < 260; i++) begin
            beat(8'(i), 1'b1);
            if (i == 9) chk("sat_count_10", 128'(err_count), 128'd10);
        end
        chk("sat_frame_err", 128'(frame_err), 128'd1);
        chk("sat_count_255", 128'(err_count), 128'd255);
        idle(2);
        chk("sat_count_hold", 128'(err_count), 128'd255);
        chk("sat_m_valid", 128'(m_valid), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
